pc_sequencer: RTL and testbench

Parametrised program-counter sequencer that replaces the fixed 5-bit PC register in the datapath. It holds the current instruction address, advances it by a configurable step, and loads branch or call targets. It also keeps a bounded return-address stack for call/return, and reports stack overflow and underflow through sticky flags. It sits between the control unit (stall/branch/call/return decisions) and instruction memory (PC output).

---
 rtl/pc_sequencer.sv | 105 ++++++++++
 tb/tb_pc_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential advance, branch/call targets and a
// bounded circular return-address stack with sticky overflow/underflow flags.
module pc_sequencer #(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      STEP     = 4,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       Stall,
  input  logic                       Branch,
  input  logic [WIDTH-1:0]           BranchTarget,
  input  logic                       Call,
  input  logic [WIDTH-1:0]           CallTarget,
  input  logic                       Ret,
  output logic [WIDTH-1:0]           PC,
  output logic [$clog2(DEPTH+1)-1:0] StackCount,
  output logic                       Overflow,
  output logic                       Underflow
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stack_mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    wr_ptr_inc;
  logic [PW-1:0]    top_ptr;
  logic [PW-1:0]    ptr_next;
  logic [WIDTH-1:0] pc_seq;
  logic [WIDTH-1:0] pc_next;
  logic [CW-1:0]    count_next;
  logic             overflow_next;
  logic             underflow_next;
  logic             stack_full;
  logic             stack_empty;
  logic             push;

  always_comb begin
    pc_seq      = PC + WIDTH'(STEP);
    wr_ptr_inc  = (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
    top_ptr     = (wr_ptr == '0) ? PW'(DEPTH - 1) : wr_ptr - PW'(1);
    stack_full  = (StackCount == CW'(DEPTH));
    stack_empty = (StackCount == '0);

    pc_next        = PC;
    count_next     = StackCount;
    ptr_next       = wr_ptr;
    overflow_next  = Overflow;
    underflow_next = Underflow;
    push           = 1'b0;

    if (!Stall) begin
      if (Ret) begin
        if (!stack_empty) begin
          pc_next    = stack_mem[top_ptr];
          count_next = StackCount - CW'(1);
          ptr_next   = top_ptr;
        end else begin
          pc_next        = pc_seq;
          underflow_next = 1'b1;
        end
      end else if (Call) begin
        // Pointer always advances; on a full stack this overwrites the oldest
        // entry while the count saturates at DEPTH.
        push     = 1'b1;
        ptr_next = wr_ptr_inc;
        pc_next  = CallTarget;
        if (stack_full) begin
          overflow_next = 1'b1;
        end else begin
          count_next = StackCount + CW'(1);
        end
      end else if (Branch) begin
        pc_next = BranchTarget;
      end else begin
        pc_next = pc_seq;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      PC         <= RESET_PC;
      StackCount <= '0;
      wr_ptr     <= '0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
    end else begin
      PC         <= pc_next;
      StackCount <= count_next;
      wr_ptr     <= ptr_next;
      Overflow   <= overflow_next;
      Underflow  <= underflow_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !Reset) begin
      stack_mem[wr_ptr] <= pc_seq;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: two instances (DEPTH=2 and DEPTH=4) share stimulus;
// a list-based return-stack model checks every cycle, plus fixed vector tables.
module tb_pc_sequencer;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0, Stall = 1'b0, Branch = 1'b0, Call = 1'b0, Ret = 1'b0;
  logic [7:0] BranchTarget = '0, CallTarget = '0;

  logic [7:0] pc_a, pc_b;
  logic [1:0] cnt_a;
  logic [2:0] cnt_b;
  logic       ovf_a, ovf_b, unf_a, unf_b;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  pc_sequencer #(.WIDTH(8), .STEP(4), .DEPTH(2), .RESET_PC(8'h10)) dut_a (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .BranchTarget(BranchTarget), .Call(Call), .CallTarget(CallTarget), .Ret(Ret),
    .PC(pc_a), .StackCount(cnt_a), .Overflow(ovf_a), .Underflow(unf_a)
  );

  pc_sequencer #(.WIDTH(8), .STEP(4), .DEPTH(4), .RESET_PC(8'h10)) dut_b (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Branch(Branch),
    .BranchTarget(BranchTarget), .Call(Call), .CallTarget(CallTarget), .Ret(Ret),
    .PC(pc_b), .StackCount(cnt_b), .Overflow(ovf_b), .Underflow(unf_b)
  );

  // Reference model: return stack as an ordered list (index 0 = oldest).
  logic [7:0] m_pc  [2];
  logic [7:0] m_stk [2][4];
  int         m_cnt [2];
  logic       m_ovf [2];
  logic       m_unf [2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      int d;
      logic [7:0] ra;
      d = (i == 0) ? 2 : 4;
      if (Reset) begin
        m_pc[i] = 8'h10; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
      end else if (Stall) begin
        // hold
      end else if (Ret) begin
        if (m_cnt[i] > 0) begin
          m_cnt[i]--;
          m_pc[i] = m_stk[i][m_cnt[i]];
        end else begin
          m_pc[i] = m_pc[i] + 8'd4;
          m_unf[i] = 1'b1;
        end
      end else if (Call) begin
        ra = m_pc[i] + 8'd4;
        if (m_cnt[i] == d) begin
          for (int k = 0; k < d - 1; k++) m_stk[i][k] = m_stk[i][k+1];
          m_stk[i][d-1] = ra;
          m_ovf[i] = 1'b1;
        end else begin
          m_stk[i][m_cnt[i]] = ra;
          m_cnt[i]++;
        end
        m_pc[i] = CallTarget;
      end else if (Branch) begin
        m_pc[i] = BranchTarget;
      end else begin
        m_pc[i] = m_pc[i] + 8'd4;
      end
    end
  endtask

  task automatic compare_model();
    check("model_pc_a",  32'(pc_a),  32'(m_pc[0]));
    check("model_cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
    check("model_ovf_a", 32'(ovf_a), 32'(m_ovf[0]));
    check("model_unf_a", 32'(unf_a), 32'(m_unf[0]));
    check("model_pc_b",  32'(pc_b),  32'(m_pc[1]));
    check("model_cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
    check("model_ovf_b", 32'(ovf_b), 32'(m_ovf[1]));
    check("model_unf_b", 32'(unf_b), 32'(m_unf[1]));
  endtask

  task automatic drive(input logic r, input logic s, input logic rt, input logic c,
                       input logic b, input logic [7:0] bt, input logic [7:0] ct);
    Reset = r; Stall = s; Ret = rt; Call = c; Branch = b;
    BranchTarget = bt; CallTarget = ct;
    @(posedge Clk);
    model_update();
    #1;
    compare_model();
  endtask

  task automatic expect_b(input string tag, input logic [7:0] pc, input int cnt,
                          input logic ovf, input logic unf);
    check({tag, "_pc"},  32'(pc_b),  32'(pc));
    check({tag, "_cnt"}, 32'(cnt_b), 32'(cnt));
    check({tag, "_ovf"}, 32'(ovf_b), 32'(ovf));
    check({tag, "_unf"}, 32'(unf_b), 32'(unf));
  endtask

  typedef struct {
    logic       rst, stall, ret, call, br;
    logic [7:0] bt, ct;
    logic [7:0] pc;
    int         cnt;
    logic       ovf, unf;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic stall, input logic ret,
                              input logic call, input logic br, input logic [7:0] bt,
                              input logic [7:0] ct, input logic [7:0] pc, input int cnt,
                              input logic ovf, input logic unf);
    vec_t v;
    v.rst = rst; v.stall = stall; v.ret = ret; v.call = call; v.br = br;
    v.bt = bt; v.ct = ct; v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.unf = unf;
    return v;
  endfunction

  initial begin
    vec_t vt[$];
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = '0; m_cnt[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end

    //              rst stl ret cal br  bt     ct     pc    cnt ovf unf   (DEPTH=2 instance)
    vt.push_back(mk(1, 0, 0, 0, 0, 8'h00, 8'h00, 8'h10, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h14, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h18, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h1C, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'hFC, 8'h00, 8'hFC, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h20, 8'h00, 8'h20, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h80, 8'h80, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h84, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h24, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h40, 8'h40, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h50, 8'h50, 2, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h60, 8'h60, 2, 1, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h54, 1, 1, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h44, 0, 1, 0));
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h48, 0, 1, 1));
    vt.push_back(mk(0, 1, 1, 0, 1, 8'h99, 8'h00, 8'h48, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 1, 0, 8'h00, 8'h70, 8'h70, 1, 1, 1));
    vt.push_back(mk(0, 0, 1, 1, 0, 8'h00, 8'h90, 8'h4C, 0, 1, 1));
    vt.push_back(mk(0, 0, 0, 1, 1, 8'hB0, 8'hA0, 8'hA0, 1, 1, 1));
    vt.push_back(mk(0, 1, 0, 1, 0, 8'h00, 8'hC0, 8'hA0, 1, 1, 1));
    vt.push_back(mk(0, 1, 0, 1, 0, 8'h00, 8'hC0, 8'hA0, 1, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h50, 0, 1, 1));
    vt.push_back(mk(1, 0, 0, 1, 0, 8'h00, 8'hC0, 8'h10, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h14, 0, 0, 0));

    foreach (vt[n]) begin
      drive(vt[n].rst, vt[n].stall, vt[n].ret, vt[n].call, vt[n].br, vt[n].bt, vt[n].ct);
      check($sformatf("vec%0d_pc", n),  32'(pc_a),  32'(vt[n].pc));
      check($sformatf("vec%0d_cnt", n), 32'(cnt_a), 32'(vt[n].cnt));
      check($sformatf("vec%0d_ovf", n), 32'(ovf_a), 32'(vt[n].ovf));
      check($sformatf("vec%0d_unf", n), 32'(unf_a), 32'(vt[n].unf));
    end

    // DEPTH=4: circular overwrite keeps the newest four return addresses in LIFO order
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00); expect_b("b_rst", 8'h10, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 8'h00, 8'h20);
    drive(0, 0, 0, 1, 0, 8'h00, 8'h30);
    drive(0, 0, 0, 1, 0, 8'h00, 8'h40);
    drive(0, 0, 0, 1, 0, 8'h00, 8'h50); expect_b("b_full", 8'h50, 4, 0, 0);
    drive(0, 0, 0, 1, 0, 8'h00, 8'h60); expect_b("b_ovf", 8'h60, 4, 1, 0);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00); expect_b("b_ret1", 8'h54, 3, 1, 0);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00); expect_b("b_ret2", 8'h44, 2, 1, 0);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00); expect_b("b_ret3", 8'h34, 1, 1, 0);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00); expect_b("b_ret4", 8'h24, 0, 1, 0);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00); expect_b("b_ret5", 8'h28, 0, 1, 1);

    // Reset arriving with a Call mid-sequence wins; nothing is pushed
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00);
    for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 0, 8'h00, 8'(8'h20 + 8'(k * 16)));
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00); expect_b("b_mid", 8'h54, 3, 1, 0);
    drive(1, 0, 0, 1, 0, 8'h00, 8'h70); expect_b("b_rstcall", 8'h10, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 8'h00, 8'h00); expect_b("b_nopush", 8'h14, 0, 0, 1);

    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, 8'($urandom), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
